dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder: the target end of the load/store requests issued by the memory-access (MEM) stage.
- Accepts one request at a time over a valid/ready handshake and applies a configurable number of wait cycles.
- Performs byte/half/word/dword little-endian reads (sign- or zero-extended) and byte-lane-masked writes.
- Returns a single response per request over a valid/ready handshake.

Parameters:
- ADDR_W, 8, dword-index width; the array holds 2^ADDR_W 64-bit words and req_addr[ADDR_W+2:3] selects the word.
- WAIT_CYC, 2, wait cycles between acceptance and response; legal range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  64  byte address.
- req_wen  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 dword.
- req_signed  in  1  sign-extend load data (ignored for dword and stores).
- req_wdata  in  64  store data, right-aligned (bits [8*n-1:0] are used).
- resp_valid  out  1  response present.
- resp_ready  in  1  MEM stage accepts the response.
- resp_rdata  out  64  load result, extended to 64 bits; 0 for stores.
- resp_err  out  1  request faulted.

Behaviour:
- Reset values (asserted rst=0, asynchronous): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0. Memory array contents are not reset.
- A request is accepted when req_valid && req_ready on a clk edge. All request fields are latched at acceptance; input changes afterwards have no effect.
- States:
  - IDLE: req_ready=1. On acceptance, go to WAIT and load the counter with WAIT_CYC; if WAIT_CYC=0, go directly to EXEC.
  - WAIT: req_ready=0. Decrement the counter each cycle; go to EXEC when it reaches 1.
  - EXEC (1 cycle): perform the array access; register resp_rdata and resp_err; go to RESP.
  - RESP: resp_valid=1 and outputs held stable. On resp_ready=1 go to IDLE, with resp_valid low in the next cycle.
- Latency: resp_valid rises WAIT_CYC+1 cycles after the acceptance edge. Throughput is one request per WAIT_CYC+3 cycles minimum.
- No new request is accepted while in RESP, i.e. there is no overlap of request and response.
- Byte offset o = req_addr[2:0]; n = 1,2,4,8 bytes for req_size 00..11.
- Loads: extract bytes o..o+n-1 of the selected word. Zero-extend, or sign-extend from bit 8n-1 when req_signed=1.
- Stores: byte enable covers bytes o..o+n-1; bytes outside the mask are unchanged. The write is committed in EXEC.
- Out of range: if req_addr[63:ADDR_W+3] != 0, then resp_err=1, resp_rdata=0, and no write occurs.
- Reset mid-operation: state returns to IDLE and any in-flight store is dropped if EXEC has not yet executed. Array contents are preserved.
- A load following a store to the same address returns the stored data; there is no hazard because accesses are serialized.

Optional Feature:
- Macro DMEM_ALIGN_CHECK_EN.
- Defined: a request with o not a multiple of n (e.g. half at o=1, word at o=2, dword at o!=0) returns resp_err=1 and resp_rdata=0, with no write. Latency is unchanged.
- Undefined: the offset is force-aligned by clearing the low log2(n) bits of o before access, and resp_err is raised only for out-of-range addresses.

Test Plan:
- Reset/idle:
  - Stimulus: hold rst=0 for 2 cycles, then release.
  - Required: req_ready=1, resp_valid=0, resp_rdata=0.
- Dword store then load, WAIT_CYC=2:
  - Stimulus: store dword 0x0000_0000_0000_0006 to addr 0x0, then load dword from 0x0.
  - Required: resp_valid exactly 3 cycles after each acceptance; load resp_rdata=0x6, resp_err=0.
- Byte-lane merge:
  - Stimulus: store dword 0x1122334455667788 to 0x8, store byte 0xAB to 0xB, then load dword from 0x8.
  - Required: resp_rdata=0x11223344AB667788.
- Extension:
  - Stimulus: store half 0x8001 to 0x10; load half unsigned from 0x10, then signed from 0x10.
  - Required: 0x0000000000008001, then 0xFFFFFFFFFFFF8001.
- Error paths:
  - Load from 0x800 with ADDR_W=8 -> resp_err=1, rdata=0.
  - With DMEM_ALIGN_CHECK_EN: word store to 0x2 -> resp_err=1, and a later load from 0x0 is unchanged.
  - Without DMEM_ALIGN_CHECK_EN: the same word store writes at 0x0.
- Backpressure and reset mid-operation:
  - Stimulus: hold resp_ready=0 for 5 cycles in RESP.
  - Required: resp_valid/resp_rdata stable and req_ready=0 throughout.
  - Stimulus: assert rst during WAIT of a store to 0x18.
  - Required: outputs at reset values immediately; a later load from 0x18 returns the old value.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: target end of MEM-stage load/store requests.
// Accepts one request at a time, waits WAIT_CYC cycles, performs a
// little-endian byte/half/word/dword access on a 64-bit-wide array and
// returns one response per request.
// Optional feature macro: DMEM_ALIGN_CHECK_EN
//   defined   -> misaligned accesses fault (resp_err=1, no write)
//   undefined -> the offset is force-aligned to the access size
module dmem_responder #(
    parameter int ADDR_W   = 8,
    parameter int WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic        req_wen,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EXEC = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

    // Byte-enable pattern for an access of the given size at offset 0.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            2'b10:   m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // Offset with the low log2(n) bits cleared.
    function automatic logic [2:0] align_off(input logic [2:0] o, input logic [1:0] size);
        logic [2:0] r;
        case (size)
            2'b00:   r = o;
            2'b01:   r = {o[2:1], 1'b0};
            2'b10:   r = {o[2], 2'b00};
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    // Zero- or sign-extend the low 8n bits of raw to 64 bits.
    function automatic logic [63:0] extend(input logic [63:0] raw, input logic [1:0] size,
                                           input logic sgn);
        logic [63:0] r;
        case (size)
            2'b00:   r = sgn ? {{56{raw[7]}},  raw[7:0]}  : {56'd0, raw[7:0]};
            2'b01:   r = sgn ? {{48{raw[15]}}, raw[15:0]} : {48'd0, raw[15:0]};
            2'b10:   r = sgn ? {{32{raw[31]}}, raw[31:0]} : {32'd0, raw[31:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

`ifdef DMEM_ALIGN_CHECK_EN
    // True when the offset is not a multiple of the access size.
    function automatic logic misaligned(input logic [2:0] o, input logic [1:0] size);
        logic r;
        case (size)
            2'b00:   r = 1'b0;
            2'b01:   r = o[0];
            2'b10:   r = |o[1:0];
            default: r = |o;
        endcase
        return r;
    endfunction
`endif

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic [63:0]         resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;

    logic [63:0]         addr_q;
    logic                wen_q;
    logic [1:0]          size_q;
    logic                signed_q;
    logic [63:0]         wdata_q;

    logic [63:0]         mem_q [0:(1<<ADDR_W)-1];

    logic                accept_s;
    logic [ADDR_W-1:0]   idx_s;
    logic                err_s;
    logic [2:0]          off_s;
    logic [5:0]          shamt_s;
    logic [63:0]         word_s;
    logic [63:0]         load_s;
    logic [7:0]          bmask_s;
    logic [63:0]         wshift_s;
    logic [63:0]         merged_s;
    logic                we_s;

    assign accept_s   = req_valid & req_ready_q;
    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    // Access datapath: fault detection, load extraction and store merge.
    always_comb begin
        idx_s = addr_q[ADDR_W+2:3];
`ifdef DMEM_ALIGN_CHECK_EN
        err_s = (|addr_q[63:ADDR_W+3]) | misaligned(addr_q[2:0], size_q);
        off_s = addr_q[2:0];
`else
        err_s = |addr_q[63:ADDR_W+3];
        off_s = align_off(addr_q[2:0], size_q);
`endif
        shamt_s  = {off_s, 3'b000};
        word_s   = mem_q[idx_s];
        load_s   = extend(word_s >> shamt_s, size_q, signed_q);
        bmask_s  = size_mask(size_q) << off_s;
        wshift_s = wdata_q << shamt_s;
        merged_s = word_s;
        for (int b = 0; b < 8; b++) begin
            if (bmask_s[b]) begin
                merged_s[8*b +: 8] = wshift_s[8*b +: 8];
            end else begin
                merged_s[8*b +: 8] = word_s[8*b +: 8];
            end
        end
        we_s = (state_q == ST_EXEC) & wen_q & ~err_s;
    end

    // Next-state, wait counter and registered-output next values.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (WAIT_CYC == 0) begin
                        state_d = ST_EXEC;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_EXEC;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            ST_EXEC: begin
                state_d      = ST_RESP;
                resp_err_d   = err_s;
                resp_rdata_d = (err_s | wen_q) ? 64'd0 : load_s;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);
    end

    // Control state, counter and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 64'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Capture all request fields at acceptance so later input changes are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= 64'd0;
            wen_q    <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            wdata_q  <= 64'd0;
        end else if (accept_s) begin
            addr_q   <= req_addr;
            wen_q    <= req_wen;
            size_q   <= req_size;
            signed_q <= req_signed;
            wdata_q  <= req_wdata;
        end
    end

    // Storage array; not reset, written only in EXEC for a non-faulting store.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_q[idx_s] <= merged_s;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder (ADDR_W=8, WAIT_CYC=2).
// Expectations follow DMEM_ALIGN_CHECK_EN when it is defined for the build.
module tb_dmem_responder;

    localparam int ADDR_W   = 8;
    localparam int WAIT_CYC = 2;
    localparam int LAT      = WAIT_CYC + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = 64'd0;
    logic        req_wen = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_err;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        wen;
        logic [1:0]  size;
        logic        sgn;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYC(WAIT_CYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wen    (req_wen),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic wen, input logic [1:0] size, input logic sgn,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [63:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.wen = wen; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    // Issue one request and wait (bounded) for resp_valid; leaves the DUT in RESP.
    task automatic do_req(input logic wen, input logic [1:0] size, input logic sgn,
                          input logic [63:0] addr, input logic [63:0] wdata, input string tag,
                          output logic [63:0] rdata, output logic err);
        int cyc;
        bit seen;
        @(negedge clk);
        check({tag, " req_ready"}, {63'd0, req_ready}, 64'd1);
        req_valid  = 1'b1;
        req_wen    = wen;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_addr   = ~addr;
        req_wen    = ~wen;
        req_size   = ~size;
        req_signed = ~sgn;
        req_wdata  = ~wdata;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (resp_valid) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: got no resp_valid expected within 40 cycles", tag);
            rdata = 64'd0;
            err   = 1'b0;
        end else begin
            check({tag, " latency"}, 64'(cyc), 64'(LAT));
            rdata = resp_rdata;
            err   = resp_err;
        end
    endtask

    // Complete the response handshake and check the DUT is idle again.
    task automatic finish_resp(input string tag);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({tag, " resp_valid drop"}, {63'd0, resp_valid}, 64'd0);
        check({tag, " idle ready"}, {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        logic [63:0] rd;
        logic        er;
        logic [63:0] held;
        string       tag;

        // Stores/loads with hand-computed results.
        add_vec(1'b1, 2'b11, 1'b0, 64'h0,  64'h0000_0000_0000_0006, 64'h0, 1'b0);
        add_vec(1'b0, 2'b11, 1'b0, 64'h0,  64'h0, 64'h0000_0000_0000_0006, 1'b0);
        add_vec(1'b1, 2'b11, 1'b0, 64'h8,  64'h1122_3344_5566_7788, 64'h0, 1'b0);
        add_vec(1'b1, 2'b00, 1'b0, 64'hB,  64'hFFFF_FFFF_FFFF_FFAB, 64'h0, 1'b0);
        add_vec(1'b0, 2'b11, 1'b0, 64'h8,  64'h0, 64'h1122_3344_AB66_7788, 1'b0);
        add_vec(1'b1, 2'b01, 1'b0, 64'h10, 64'h0000_0000_00AA_8001, 64'h0, 1'b0);
        add_vec(1'b0, 2'b01, 1'b0, 64'h10, 64'h0, 64'h0000_0000_0000_8001, 1'b0);
        add_vec(1'b0, 2'b01, 1'b1, 64'h10, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 1'b0);
        add_vec(1'b0, 2'b00, 1'b1, 64'hB,  64'h0, 64'hFFFF_FFFF_FFFF_FFAB, 1'b0);
        add_vec(1'b0, 2'b10, 1'b0, 64'hC,  64'h0, 64'h0000_0000_1122_3344, 1'b0);
        add_vec(1'b0, 2'b10, 1'b1, 64'hC,  64'h0, 64'h0000_0000_1122_3344, 1'b0);
        add_vec(1'b0, 2'b00, 1'b0, 64'h8,  64'h0, 64'h0000_0000_0000_0088, 1'b0);
        add_vec(1'b0, 2'b10, 1'b1, 64'h8,  64'h0, 64'hFFFF_FFFF_AB66_7788, 1'b0);
        // Out of range: load and store fault; the store must not alias onto 0x0.
        add_vec(1'b0, 2'b11, 1'b0, 64'h800, 64'h0, 64'h0, 1'b1);
        add_vec(1'b1, 2'b11, 1'b0, 64'h800, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        add_vec(1'b0, 2'b11, 1'b0, 64'h0,   64'h0, 64'h0000_0000_0000_0006, 1'b0);
        add_vec(1'b0, 2'b11, 1'b0, 64'h8000_0000_0000_0010, 64'h0, 64'h0, 1'b1);
        // Misaligned accesses.
`ifdef DMEM_ALIGN_CHECK_EN
        add_vec(1'b1, 2'b10, 1'b0, 64'h2,  64'hCAFE_BABE, 64'h0, 1'b1);
        add_vec(1'b0, 2'b11, 1'b0, 64'h0,  64'h0, 64'h0000_0000_0000_0006, 1'b0);
        add_vec(1'b0, 2'b10, 1'b1, 64'h0,  64'h0, 64'h0000_0000_0000_0006, 1'b0);
        add_vec(1'b0, 2'b01, 1'b0, 64'h11, 64'h0, 64'h0, 1'b1);
        add_vec(1'b0, 2'b11, 1'b0, 64'hB,  64'h0, 64'h0, 1'b1);
`else
        add_vec(1'b1, 2'b10, 1'b0, 64'h2,  64'hCAFE_BABE, 64'h0, 1'b0);
        add_vec(1'b0, 2'b11, 1'b0, 64'h0,  64'h0, 64'h0000_0000_CAFE_BABE, 1'b0);
        add_vec(1'b0, 2'b10, 1'b1, 64'h0,  64'h0, 64'hFFFF_FFFF_CAFE_BABE, 1'b0);
        add_vec(1'b0, 2'b01, 1'b0, 64'h11, 64'h0, 64'h0000_0000_0000_8001, 1'b0);
        add_vec(1'b0, 2'b11, 1'b0, 64'hB,  64'h0, 64'h1122_3344_AB66_7788, 1'b0);
`endif
        add_vec(1'b1, 2'b00, 1'b0, 64'h17, 64'h0000_0000_0000_0080, 64'h0, 1'b0);
        add_vec(1'b0, 2'b00, 1'b1, 64'h17, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        add_vec(1'b1, 2'b11, 1'b0, 64'h18, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 1'b0);

        // Reset / idle.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset req_ready",  {63'd0, req_ready},  64'd1);
        check("reset resp_valid", {63'd0, resp_valid}, 64'd0);
        rst = 1'b1;
        #1;
        check("idle req_ready",  {63'd0, req_ready},  64'd1);
        check("idle resp_valid", {63'd0, resp_valid}, 64'd0);
        check("idle resp_rdata", resp_rdata, 64'd0);
        check("idle resp_err",   {63'd0, resp_err},   64'd0);

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            tag = $sformatf("v%0d", i);
            do_req(vecs[i].wen, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                   tag, rd, er);
            check({tag, " rdata"}, rd, vecs[i].exp_rdata);
            check({tag, " err"}, {63'd0, er}, {63'd0, vecs[i].exp_err});
            finish_resp(tag);
        end

        // Backpressure: hold resp_ready low for 5 cycles in RESP.
        do_req(1'b0, 2'b11, 1'b0, 64'h18, 64'h0, "bp", rd, er);
        check("bp rdata", rd, 64'hDEAD_BEEF_CAFE_F00D);
        held = rd;
        req_valid = 1'b1;
        req_addr  = 64'h20;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp%0d resp_valid", k), {63'd0, resp_valid}, 64'd1);
            check($sformatf("bp%0d resp_rdata", k), resp_rdata, held);
            check($sformatf("bp%0d req_ready", k),  {63'd0, req_ready},  64'd0);
        end
        req_valid = 1'b0;
        finish_resp("bp");

        // Reset during WAIT of a store to 0x18: store dropped, outputs reset at once.
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_size  = 2'b11;
        req_addr  = 64'h18;
        req_wdata = 64'h5555_5555_5555_5555;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst req_ready",  {63'd0, req_ready},  64'd1);
        check("midrst resp_valid", {63'd0, resp_valid}, 64'd0);
        check("midrst resp_rdata", resp_rdata, 64'd0);
        check("midrst resp_err",   {63'd0, resp_err},   64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        do_req(1'b0, 2'b11, 1'b0, 64'h18, 64'h0, "postrst", rd, er);
        check("postrst rdata", rd, 64'hDEAD_BEEF_CAFE_F00D);
        check("postrst err", {63'd0, er}, 64'd0);
        finish_resp("postrst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
